// File: rtl/uart_mmio.sv
// Memory-mapped UART with TX buffer, RX double-flop synchronizer and level IRQ.
// Define UART_MMIO_TX_FIFO_EN for a TX_DEPTH-entry TX FIFO; otherwise a single holding register is used.
module uart_mmio #(
   parameter int CLKS_PER_BIT = 868,
   parameter int TX_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   input  logic        Rx_Serial,
   output logic        Tx_Serial,
   output logic        IRQ
);

   localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
   localparam logic [31:0] ADDR_CON = 32'h4000_0020;
   localparam int          CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic wr_txd, wr_con, rd_rxd;
   logic tx_push, tx_pop, tx_full, tx_empty, tx_busy;
   logic [7:0] tx_head;
   logic tx_irq_en, rx_irq_en;
   logic [7:0] rx_data;
   logic rx_valid, rx_overrun, rx_load;
   logic unused_bits;

   assign wr_txd      = MemWrite && (address == ADDR_TXD);
   assign wr_con      = MemWrite && (address == ADDR_CON);
   assign rd_rxd      = MemRead  && (address == ADDR_RXD);
   assign unused_bits = &{1'b0, write_data[31:8]};

`ifdef UART_MMIO_TX_FIFO_EN
   localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam logic [AW:0] FIFO_FULL = (AW+1)'(TX_DEPTH);

   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_count;

   assign tx_full  = (fifo_count == FIFO_FULL);
   assign tx_empty = (fifo_count == '0);
   assign tx_head  = fifo_mem[rd_ptr];
   assign tx_push  = wr_txd && (!tx_full || tx_pop);

   always_ff @(posedge clk) begin
      if (tx_push) fifo_mem[wr_ptr] <= write_data[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (tx_push) wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end
`else
   logic [7:0] hold_data;
   logic       hold_valid;

   assign tx_full  = hold_valid;
   assign tx_empty = !hold_valid;
   assign tx_head  = hold_data;
   assign tx_push  = wr_txd && (!hold_valid || tx_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_data  <= 8'h00;
         hold_valid <= 1'b0;
      end else if (tx_push) begin
         hold_data  <= write_data[7:0];
         hold_valid <= 1'b1;
      end else if (tx_pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   uart_state_t tx_state, tx_next;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_shift, tx_shift_n;

   assign tx_busy = (tx_state != IDLE);

   // The line register lags the state by one cycle, so each bit still lasts CLKS_PER_BIT cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state  <= IDLE;
         tx_cnt    <= '0;
         tx_bit    <= 3'd0;
         tx_shift  <= 8'h00;
         Tx_Serial <= 1'b1;
      end else begin
         tx_state  <= tx_next;
         tx_cnt    <= tx_cnt_n;
         tx_bit    <= tx_bit_n;
         tx_shift  <= tx_shift_n;
         Tx_Serial <= (tx_state == START) ? 1'b0 :
                      (tx_state == DATA)  ? tx_shift[0] : 1'b1;
      end
   end

   always_comb begin
      tx_next    = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_pop     = 1'b0;
      case (tx_state)
         IDLE: begin
            tx_cnt_n = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_n = tx_head;
               tx_next    = START;
            end
         end
         START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               tx_bit_n = 3'd0;
               tx_next  = DATA;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n   = '0;
               tx_shift_n = {1'b0, tx_shift[7:1]};
               if (tx_bit == 3'd7) tx_next = STOP;
               else                tx_bit_n = tx_bit + 3'd1;
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               // Chain straight into the next frame when more data is waiting.
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_n = tx_head;
                  tx_next    = START;
               end else begin
                  tx_next = IDLE;
               end
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         default: tx_next = IDLE;
      endcase
   end

   // Sync flops reset low so a line held low across reset is not mistaken for a start bit.
   logic rx_s1, rx_s2, rx_prev;
   uart_state_t rx_state, rx_next;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_shift, rx_shift_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1    <= 1'b0;
         rx_s2    <= 1'b0;
         rx_prev  <= 1'b0;
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
      end else begin
         rx_s1    <= Rx_Serial;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_next;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
      end
   end

   always_comb begin
      rx_next    = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_load    = 1'b0;
      case (rx_state)
         IDLE: begin
            rx_cnt_n = '0;
            if (rx_prev && !rx_s2) rx_next = START;
         end
         START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n = '0;
               rx_bit_n = 3'd0;
               rx_next  = rx_s2 ? IDLE : DATA;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_s2, rx_shift[7:1]};
               if (rx_bit == 3'd7) rx_next = STOP;
               else                rx_bit_n = rx_bit + 3'd1;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n = '0;
               rx_load  = rx_s2;
               rx_next  = IDLE;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         default: rx_next = IDLE;
      endcase
   end

   // A new byte wins over a same-edge RXD read; overrun only if the old byte was left unread.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         tx_irq_en  <= 1'b0;
         rx_irq_en  <= 1'b0;
      end else begin
         if (wr_con) begin
            tx_irq_en <= write_data[0];
            rx_irq_en <= write_data[1];
            if (write_data[4]) rx_overrun <= 1'b0;
         end
         if (rx_load) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rd_rxd) rx_overrun <= 1'b1;
         end else if (rd_rxd) begin
            rx_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      read_data = 32'h0;
      if (MemRead) begin
         if (address == ADDR_RXD)
            read_data = {24'h0, rx_data};
         else if (address == ADDR_CON)
            read_data = {26'h0, tx_full, rx_overrun, rx_valid, tx_busy, rx_irq_en, tx_irq_en};
      end
   end

   assign IRQ = (rx_irq_en && rx_valid) || (tx_irq_en && tx_empty && !tx_busy);

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: a serial monitor decodes Tx_Serial into a queue
// that the scenario tasks compare against expected bytes pushed at stimulus time.
module tb_uart_mmio;

   localparam int C     = 4;
   localparam int DEPTH = 4;
`ifdef UART_MMIO_TX_FIFO_EN
   localparam int BUF = DEPTH;
`else
   localparam int BUF = 1;
`endif
   localparam logic [31:0] A_TXD = 32'h4000_0018;
   localparam logic [31:0] A_RXD = 32'h4000_001C;
   localparam logic [31:0] A_CON = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] address = 32'h0;
   logic [31:0] write_data = 32'h0;
   logic [31:0] read_data;
   logic        Rx_Serial = 1'b1;
   logic        Tx_Serial;
   logic        IRQ;

   int errors = 0;
   int checks = 0;
   logic [8:0] got_q[$];
   logic [7:0] exp_q[$];

   uart_mmio #(.CLKS_PER_BIT(C), .TX_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .address(address), .write_data(write_data), .read_data(read_data),
      .Rx_Serial(Rx_Serial), .Tx_Serial(Tx_Serial), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   // Decode frames off the line, sampling near mid-bit on falling clock edges.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (Tx_Serial === 1'b0) begin
            repeat (C/2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               b[i] = Tx_Serial;
            end
            repeat (C) @(negedge clk);
            got_q.push_back({Tx_Serial, b});
         end
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit last);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b1; address = a; write_data = d;
      @(posedge clk);
      if (last) begin
         @(negedge clk);
         MemWrite = 1'b0; address = 32'h0;
      end
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b1; address = a;
      #1 d = read_data;
      @(negedge clk);
      MemRead = 1'b0; address = 32'h0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      @(negedge clk) Rx_Serial = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         Rx_Serial = b[i];
         repeat (C) @(negedge clk);
      end
      Rx_Serial = stop_bit;
      repeat (C) @(negedge clk);
      Rx_Serial = 1'b1;
      repeat (3*C) @(negedge clk);
   endtask

   task automatic wait_got(input int n, input string name);
      int cyc = 0;
      while (got_q.size() < n && cyc < 14*C*(n+1)) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (got_q.size() < n) begin
         errors++;
         $display("[TB] FAIL %s timeout: got %0d frames, required %0d", name, got_q.size(), n);
      end
   endtask

   task automatic drain_scoreboard(input string name);
      logic [7:0] e;
      logic [8:0] g;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         checks++;
         if (g !== {1'b1, e}) begin
            errors++;
            $display("[TB] FAIL %s byte: got stop/data %h, required %h", name, g, {1'b1, e});
         end
      end
      checks++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s count: %0d extra frames, %0d missing", name, got_q.size(), exp_q.size());
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (2) @(negedge clk);
      MemRead = 1'b1; address = A_CON;
      #1;
      checks += 3;
      if (Tx_Serial !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b, required 1", Tx_Serial); end
      if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b, required 0", IRQ); end
      if (read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_con: got %h, required 0", read_data); end
      MemRead = 1'b0; address = 32'h0;
      @(negedge clk) reset = 1'b1;
      repeat (3) @(negedge clk);
      bus_read(A_RXD, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_rxd: got %h, required 0", d); end
   endtask

   task automatic test_tx_frame();
      logic [9:0] frame;
      logic [31:0] d;
      int bad;
      frame = {1'b1, 8'hA5, 1'b0};
      exp_q.push_back(8'hA5);
      bus_write(A_TXD, 32'hFFFF_FFA5, 1'b1);
      checks += 2;
      if (Tx_Serial !== 1'b1) begin errors++; $display("[TB] FAIL tx_lat0: got %b, required 1", Tx_Serial); end
      @(negedge clk);
      if (Tx_Serial !== 1'b1) begin errors++; $display("[TB] FAIL tx_lat1: got %b, required 1", Tx_Serial); end
      for (int bitn = 0; bitn < 10; bitn++) begin
         bad = 0;
         for (int k = 0; k < C; k++) begin
            @(negedge clk);
            if (Tx_Serial !== frame[bitn]) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("[TB] FAIL tx_bit%0d: %0d cycles differ from required %b", bitn, bad, frame[bitn]);
         end
      end
      wait_got(1, "tx_frame");
      drain_scoreboard("tx_frame");
      bus_read(A_CON, d);
      checks++;
      if (d[2] !== 1'b0) begin errors++; $display("[TB] FAIL tx_busy_end: got %b, required 0", d[2]); end
      bus_write(A_CON, 32'h1, 1'b1);
      checks++;
      if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL tx_irq: got %b, required 1", IRQ); end
      bus_write(A_CON, 32'h0, 1'b1);
   endtask

   task automatic burst(input int n, input string name);
      logic [31:0] d;
      int acc = 0;
      for (int i = 0; i < n; i++) begin
         if (i < BUF + 1) begin
            exp_q.push_back(8'(i + 1));
            acc++;
         end
         bus_write(A_TXD, 32'(i + 1), i == n - 1);
      end
      bus_read(A_CON, d);
      checks++;
      if (d[5] !== 1'b1) begin errors++; $display("[TB] FAIL %s_full: got %b, required 1", name, d[5]); end
      wait_got(acc, name);
      drain_scoreboard(name);
      repeat (2*C) @(negedge clk);
      bus_read(A_CON, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL %s_con_idle: got %h, required 0", name, d); end
   endtask

   task automatic test_back_to_back();
      burst(5, "back_to_back");
   endtask

   task automatic test_overflow();
      burst(6, "overflow");
   endtask

   task automatic test_rx_byte();
      logic [31:0] d;
      logic [7:0] e;
      exp_q.push_back(8'h3C);
      bus_write(A_CON, 32'h2, 1'b1);
      send_rx(8'h3C, 1'b1);
      checks++;
      if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL rx_irq_set: got %b, required 1", IRQ); end
      e = exp_q.pop_front();
      bus_read(A_RXD, d);
      checks++;
      if (d !== {24'h0, e}) begin errors++; $display("[TB] FAIL rx_data: got %h, required %h", d, e); end
      checks++;
      if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL rx_irq_clr: got %b, required 0", IRQ); end
      bus_read(A_CON, d);
      checks++;
      if (d[3] !== 1'b0) begin errors++; $display("[TB] FAIL rx_valid_clr: got %b, required 0", d[3]); end
   endtask

   task automatic test_rx_overrun();
      logic [31:0] d;
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      bus_read(A_CON, d);
      checks++;
      if (d[4:3] !== 2'b11) begin errors++; $display("[TB] FAIL ovr_flags: got %b, required 11", d[4:3]); end
      bus_read(A_RXD, d);
      checks++;
      if (d !== 32'h22) begin errors++; $display("[TB] FAIL ovr_data: got %h, required 22", d); end
      bus_write(A_CON, 32'h10, 1'b1);
      bus_read(A_CON, d);
      checks++;
      if (d[4] !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b, required 0", d[4]); end
   endtask

   task automatic test_rx_errors();
      logic [31:0] d;
      @(negedge clk) Rx_Serial = 1'b0;
      @(negedge clk) Rx_Serial = 1'b1;
      repeat (12*C) @(negedge clk);
      bus_read(A_CON, d);
      checks++;
      if (d[3] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b, required 0", d[3]); end
      send_rx(8'h55, 1'b0);
      bus_read(A_CON, d);
      checks++;
      if (d[4:3] !== 2'b00) begin errors++; $display("[TB] FAIL frame_err_flags: got %b, required 00", d[4:3]); end
      bus_read(A_RXD, d);
      checks++;
      if (d !== 32'h22) begin errors++; $display("[TB] FAIL frame_err_data: got %h, required 22", d); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      int lows = 0;
      bus_write(A_CON, 32'h3, 1'b0);
      bus_write(A_TXD, 32'h5A, 1'b0);
      bus_write(A_TXD, 32'h66, 1'b1);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      MemRead = 1'b1; address = A_CON;
      #1;
      checks += 3;
      if (Tx_Serial !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_tx: got %b, required 1", Tx_Serial); end
      if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_irq: got %b, required 0", IRQ); end
      if (read_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_con: got %h, required 0", read_data); end
      MemRead = 1'b0; address = 32'h0;
      @(negedge clk) reset = 1'b1;
      for (int k = 0; k < 15*C; k++) begin
         @(negedge clk);
         if (Tx_Serial !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin errors++; $display("[TB] FAIL rst_mid_fifo: %0d low cycles after reset, required 0", lows); end
      bus_read(A_CON, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_con_after: got %h, required 0", d); end
      got_q.delete();
   endtask

   initial begin
      $display("[TB] uart_mmio bench, CLKS_PER_BIT=%0d, buffer entries=%0d", C, BUF);
      test_reset();
      test_tx_frame();
      test_back_to_back();
      test_overflow();
      test_rx_byte();
      test_rx_overrun();
      test_rx_errors();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
